timer_seq_ctrl: RTL
===================

TIMER_SEQ_CTRL -- requirements
Module: timer_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 4: count/limit width in bits, N >= 2.
REQ-002 SHALL have parameter DIV, default 1: clock cycles per count step (prescale), DIV >= 1.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a run.
REQ-006 SHALL have port stop  input  1  abort/clear request; highest priority after reset.
REQ-007 SHALL have port pause  input  1  level; freezes the run while high.
REQ-008 SHALL have port periodic  input  1  run mode: 1 = auto-reload, 0 = one-shot; sampled with start.
REQ-009 SHALL have port limit  input  N  terminal count value; sampled with start.
REQ-010 SHALL have port count  output  N  current count value, registered.
REQ-011 SHALL have port tick  output  1  one-cycle pulse on each terminal event, registered.
REQ-012 SHALL have port busy  output  1  high in RUN or HOLD.
REQ-013 SHALL have port done  output  1  high while in DONE.

Function
REQ-014 SHALL implement states IDLE, RUN, HOLD and DONE, with a prescaler of width ceil(log2(DIV)) (minimum 1 bit).
REQ-015 SHALL, in IDLE or DONE, on start=1 with stop=0 and limit!=0: capture limit and periodic into internal registers, set count=0 and prescaler=0, and go to RUN.
REQ-016 SHALL ignore start when limit==0 (state unchanged) and SHALL ignore start in RUN or HOLD (no restart).
REQ-017 SHALL define a step event in RUN as prescaler==DIV-1; on a step event the prescaler SHALL clear, otherwise it SHALL increment.
REQ-018 SHALL, on a step event with count != captured limit, increment count by 1.
REQ-019 SHALL, on a step event with count == captured limit, pulse tick for exactly one cycle; if periodic, set count=0 and stay in RUN; if one-shot, hold count at limit and go to DONE.
REQ-020 SHALL give a period of (limit+1)*DIV clock cycles between ticks in periodic mode.
REQ-021 SHALL, in RUN with pause=1, go to HOLD with count and prescaler frozen and no step taken that cycle; in HOLD with pause=0, return to RUN.
REQ-022 SHALL apply this priority in RUN, HOLD and DONE: stop > pause > step/start. On stop: go to IDLE, count=0, prescaler=0, tick=0.
REQ-023 SHALL keep done high in DONE until start (re-run) or stop (to IDLE) is accepted.
REQ-024 SHALL make limit/periodic changes after capture take effect only at the next accepted start.
REQ-025 SHALL keep count values within 0..captured limit and SHALL NOT wrap through 2^N.

Reset
REQ-026 SHALL, while reset=1 (asynchronously), force state=IDLE, count=0, prescaler=0, captured limit=0, captured periodic=0, tick=0, busy=0 and done=0, including mid-run.
REQ-027 SHALL resume in IDLE after reset deassertion; start is accepted from the first rising edge with reset=0.

Verification (N=4)
REQ-028 SHALL cover: reset asserted mid-RUN with count=5 -> count=0, busy=0, tick=0 and done=0 immediately, without waiting for a clock edge.
REQ-029 SHALL cover: DIV=1, one-shot, limit=3, start at edge E -> count reads 0,1,2,3 after edges E..E+3; tick=1 and done=1 after E+4; count holds 3.
REQ-030 SHALL cover: DIV=2, periodic, limit=2 -> count sequence 0,0,1,1,2,2,0,...; tick every 6 cycles; busy stays 1.
REQ-031 SHALL cover: DIV=1, limit=9, pause high for 3 cycles at count=4 -> busy=1, count=4 for the 3 cycles, then continues 5,6,...; tick is delayed by exactly 3 cycles.
REQ-032 SHALL cover: stop asserted together with pause in HOLD -> IDLE, count=0, busy=0; a later start with limit=0 -> state stays IDLE, busy=0.
REQ-033 SHALL cover: start pulsed in RUN -> ignored; start with stop=1 in DONE -> IDLE, done=0, count=0.

Source files
------------

// File: rtl/timer_seq_ctrl.sv
// Prescaled run/hold/done timer with one-shot or auto-reload operation.
// Limit and mode are captured on an accepted start and stay fixed until the next one.
module timer_seq_ctrl #(
    parameter int N   = 4,
    parameter int DIV = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         periodic,
    input  logic [N-1:0] limit,
    output logic [N-1:0] count,
    output logic         tick,
    output logic         busy,
    output logic         done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  count_q, count_d;
    logic [N-1:0]  limit_q, limit_d;
    logic          periodic_q, periodic_d;
    logic [PW-1:0] ps_q, ps_d;
    logic          tick_q, tick_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        limit_d    = limit_q;
        periodic_d = periodic_q;
        ps_d       = ps_q;
        tick_d     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                    ps_d    = '0;
                // A held pause also blocks a restart out of DONE.
                end else if (start && (limit != '0) && !((state_q == DONE) && pause)) begin
                    state_d    = RUN;
                    count_d    = '0;
                    ps_d       = '0;
                    limit_d    = limit;
                    periodic_d = periodic;
                end
            end
            RUN, HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                    ps_d    = '0;
                end else if (pause) begin
                    state_d = HOLD;
                end else begin
                    // Leaving HOLD takes a step on the same cycle so pause delays by exactly its length.
                    state_d = RUN;
                    if (ps_q == PS_MAX) begin
                        ps_d = '0;
                        if (count_q != limit_q) begin
                            count_d = count_q + 1'b1;
                        end else begin
                            tick_d = 1'b1;
                            if (periodic_q) begin
                                count_d = '0;
                            end else begin
                                state_d = DONE;
                            end
                        end
                    end else begin
                        ps_d = ps_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                ps_d    = '0;
            end
        endcase

        busy_d = (state_d == RUN) || (state_d == HOLD);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            limit_q    <= '0;
            periodic_q <= 1'b0;
            ps_q       <= '0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            limit_q    <= limit_d;
            periodic_q <= periodic_d;
            ps_q       <= ps_d;
            tick_q     <= tick_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
